// File: rtl/loader_pkg.sv
// Shared types for the UART boot-image loader.
package loader_pkg;
   typedef enum logic [1:0] {HDR, PAYLOAD, CKSUM, DONE} loader_state_e;
   typedef logic [31:0] word_t;
   localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/loader_word_assembler.sv
// Little-endian byte-to-word assembler; word/word_valid show the word as completed by the current byte.
module loader_word_assembler
   import loader_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       byte_vld,
   input  logic [7:0] byte_in,
   input  logic [2:0] nbytes,
   output word_t      word,
   output logic       word_valid
);
   logic [1:0] lane;
   word_t      acc;

   // Lane 0 starts a fresh word so short (header) words come out zero-extended.
   always_comb begin
      word = (lane == 2'd0) ? '0 : acc;
      word[{lane, 3'b000} +: 8] = byte_in;
      word_valid = byte_vld && ((3'(lane) + 3'd1) == nbytes);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane <= 2'd0;
         acc  <= '0;
      end else if (clear) begin
         lane <= 2'd0;
      end else if (byte_vld) begin
         acc  <= word;
         lane <= word_valid ? 2'd0 : lane + 2'd1;
      end
   end
endmodule

// File: rtl/uart_program_loader.sv
// Boot-image loader: count header, little-endian payload words to instruction memory, then core release.
// Optional trailer checksum state enabled by defining LOADER_CHECKSUM_EN.
module uart_program_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W      = 15,
   parameter int BASE_ADDR   = 0,
   parameter int CNT_BYTES   = 1,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic              sys_clock,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              reload,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_rst_n,
   output logic              busy,
   output logic              load_done,
   output logic              load_err
);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam logic [31:0] TO_LIM = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);
`ifdef LOADER_CHECKSUM_EN
   localparam loader_state_e TAIL = CKSUM;
`else
   localparam loader_state_e TAIL = DONE;
`endif

   loader_state_e state;
   logic [15:0]   words_left;
   logic [31:0]   tcnt;
   word_t         asm_word;
   logic          asm_valid;
   logic          accept, timeout_hit, restart;
   logic [2:0]    asm_len;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]    cksum;
`endif

   assign accept      = rx_valid && (state == HDR || state == PAYLOAD);
   assign restart     = reload && (state == DONE);
   assign asm_len     = (state == HDR) ? 3'(CNT_BYTES) : 3'(BYTES_PER_WORD);
   assign timeout_hit = (TIMEOUT_CYC != 0) && busy && !rx_valid && (state != DONE) && (tcnt == TO_LIM);

   loader_word_assembler u_asm (
      .clk        (sys_clock),
      .rst_n      (reset),
      .clear      (timeout_hit || restart),
      .byte_vld   (accept),
      .byte_in    (rx_data),
      .nbytes     (asm_len),
      .word       (asm_word),
      .word_valid (asm_valid)
   );

   always_ff @(posedge sys_clock or negedge reset) begin
      if (!reset) begin
         state      <= HDR;
         mem_we     <= 1'b0;
         mem_addr   <= BASE;
         mem_wdata  <= '0;
         core_rst_n <= 1'b0;
         busy       <= 1'b0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
         words_left <= '0;
         tcnt       <= '0;
`ifdef LOADER_CHECKSUM_EN
         cksum      <= '0;
`endif
      end else begin
         mem_we <= 1'b0;
         // Address advances in the cycle after each write strobe, wrapping silently.
         if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
         if (rx_valid || !busy) tcnt <= '0;
         else                   tcnt <= tcnt + 32'd1;

         if (timeout_hit) begin
            state    <= HDR;
            busy     <= 1'b0;
            load_err <= 1'b1;
            mem_addr <= BASE;
         end else begin
            case (state)
               HDR: if (accept) begin
                  busy <= 1'b1;
                  if (asm_valid) begin
                     words_left <= asm_word[15:0];
                     state      <= (asm_word[15:0] == 16'd0) ? TAIL : PAYLOAD;
`ifdef LOADER_CHECKSUM_EN
                     cksum      <= '0;
`endif
                  end
               end
               PAYLOAD: if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                  cksum <= cksum ^ rx_data;
`endif
                  if (asm_valid) begin
                     mem_we     <= 1'b1;
                     mem_wdata  <= asm_word;
                     words_left <= words_left - 16'd1;
                     if (words_left == 16'd1) state <= TAIL;
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               CKSUM: if (rx_valid) begin
                  if (rx_data != cksum) load_err <= 1'b1;
                  state <= DONE;
               end
`else
               CKSUM: state <= DONE;
`endif
               DONE: begin
                  busy       <= 1'b0;
                  load_done  <= 1'b1;
                  core_rst_n <= 1'b1;
                  if (reload) begin
                     state      <= HDR;
                     load_done  <= 1'b0;
                     core_rst_n <= 1'b0;
                     load_err   <= 1'b0;
                     mem_addr   <= BASE;
                  end
               end
               default: state <= HDR;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader (default and LOADER_CHECKSUM_EN builds).
module tb_uart_program_loader;
   localparam int TO = 40;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CKS_EN = 1'b1;
`else
   localparam bit CKS_EN = 1'b0;
`endif

   typedef logic [7:0] bq_t[$];
   typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
   typedef wr_t wq_t[$];
   typedef struct { int n; int gap; bit corrupt; bit exp_err; } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [7:0]  rx_data, w_rx_data;
   logic        rx_valid, w_rx_valid, reload, w_reload;
   logic        mem_we, core_rst_n, busy, load_done, load_err;
   logic [14:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        w_mem_we, w_core_rst_n, w_busy, w_load_done, w_load_err;
   logic [1:0]  w_mem_addr;
   logic [31:0] w_mem_wdata;

   int errors = 0;
   int checks = 0;
   wq_t obs_q, wobs_q;

   uart_program_loader #(.ADDR_W(15), .BASE_ADDR(0), .CNT_BYTES(1), .TIMEOUT_CYC(TO)) u_dut (
      .sys_clock(clk), .reset(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .reload(reload),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_rst_n(core_rst_n),
      .busy(busy), .load_done(load_done), .load_err(load_err));

   uart_program_loader #(.ADDR_W(2), .BASE_ADDR(3), .CNT_BYTES(1), .TIMEOUT_CYC(TO)) u_wrap (
      .sys_clock(clk), .reset(rst_n), .rx_data(w_rx_data), .rx_valid(w_rx_valid), .reload(w_reload),
      .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .core_rst_n(w_core_rst_n),
      .busy(w_busy), .load_done(w_load_done), .load_err(w_load_err));

   always @(negedge clk) begin
      if (mem_we)   obs_q.push_back('{32'(mem_addr), mem_wdata});
      if (w_mem_we) wobs_q.push_back('{32'(w_mem_addr), w_mem_wdata});
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] xor_payload(input bq_t img);
      logic [7:0] x = 8'h00;
      for (int i = 1; i <= 4 * int'(img[0]); i++) x = x ^ img[i];
      return x;
   endfunction

   function automatic void make_image(input int n, input bit corrupt, output bq_t img);
      img = {};
      img.push_back(8'(n));
      for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
      if (CKS_EN) img.push_back(xor_payload(img) ^ {7'b0, corrupt});
   endfunction

   // Reference: payload word i lands at (base + i) mod 2^aw, bytes little-endian.
   function automatic void model(input bq_t img, input int base, input int aw, output wq_t exp);
      exp = {};
      for (int i = 0; i < int'(img[0]); i++) begin
         wr_t w;
         w.addr = 32'((base + i) % (1 << aw));
         w.data = {img[4*i+4], img[4*i+3], img[4*i+2], img[4*i+1]};
         exp.push_back(w);
      end
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap, input bit w);
      if (w) begin w_rx_data = b; w_rx_valid = 1'b1; end
      else   begin rx_data = b;   rx_valid = 1'b1;   end
      @(posedge clk); #1;
      rx_valid = 1'b0; w_rx_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic send_image(input bq_t img, input int gap, input bit w);
      foreach (img[i]) send_byte(img[i], gap, w);
   endtask

   task automatic settle();
      repeat (3) begin @(posedge clk); #1; end
   endtask

   task automatic cmp_writes(input string tag, input wq_t exp, input bit w);
      wq_t o;
      o = w ? wobs_q : obs_q;
      chk({tag, "_wr_count"}, o.size(), exp.size());
      foreach (exp[i]) if (i < o.size()) begin
         chk($sformatf("%s_addr%0d", tag, i), o[i].addr, exp[i].addr);
         chk($sformatf("%s_data%0d", tag, i), o[i].data, exp[i].data);
      end
      obs_q = {}; wobs_q = {};
   endtask

   task automatic do_reload(input string tag);
      reload = 1'b1;
      @(posedge clk); #1;
      reload = 1'b0;
      chk({tag, "_rl_done"}, load_done, 0);
      chk({tag, "_rl_corerst"}, core_rst_n, 0);
      chk({tag, "_rl_err"}, load_err, 0);
      chk({tag, "_rl_addr"}, mem_addr, 0);
   endtask

   initial begin
      vec_t vt[5];
      bq_t  img;
      wq_t  exp;

      vt[0] = '{3, 5, 1'b0, 1'b0};
      vt[1] = '{0, 1, 1'b0, 1'b0};
      vt[2] = '{1, 0, 1'b0, 1'b0};
      vt[3] = '{5, 2, 1'b0, 1'b0};
      vt[4] = '{2, 3, 1'b1, CKS_EN};

      rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; reload = 1'b0;
      w_rx_data = '0; w_rx_valid = 1'b0; w_reload = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("rst_we", mem_we, 0);       chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0); chk("rst_corerst", core_rst_n, 0);
      chk("rst_busy", busy, 0);       chk("rst_done", load_done, 0);
      chk("rst_err", load_err, 0);    chk("rst_waddr", w_mem_addr, 3);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Fixed three-word image; exact write-strobe timing on the last word.
      img = {8'h03};
      repeat (3) img = {img, 8'h01, 8'h02, 8'h03, 8'h04};
      for (int i = 0; i < 12; i++) send_byte(img[i], 5, 1'b0);
      send_byte(img[12], 0, 1'b0);
      chk("t1_we", mem_we, 1);
      chk("t1_addr", mem_addr, 2);
      chk("t1_wdata", mem_wdata, 32'h04030201);
      chk("t1_busy", busy, 1);
      @(posedge clk); #1;
      chk("t1_we_pulse", mem_we, 0);
      if (CKS_EN) send_byte(xor_payload(img), 0, 1'b0);
      settle();
      model(img, 0, 15, exp);
      cmp_writes("t1", exp, 1'b0);
      chk("t1_done", load_done, 1);
      chk("t1_corerst", core_rst_n, 1);
      chk("t1_err", load_err, 0);
      do_reload("t1");

      // Table of image shapes with random payloads.
      for (int v = 0; v < 5; v++) begin
         make_image(vt[v].n, vt[v].corrupt, img);
         model(img, 0, 15, exp);
         send_image(img, vt[v].gap, 1'b0);
         settle();
         cmp_writes($sformatf("vec%0d", v), exp, 1'b0);
         chk($sformatf("vec%0d_done", v), load_done, 1);
         chk($sformatf("vec%0d_corerst", v), core_rst_n, 1);
         chk($sformatf("vec%0d_busy", v), busy, 0);
         chk($sformatf("vec%0d_err", v), load_err, 32'(vt[v].exp_err));
         do_reload($sformatf("vec%0d", v));
      end

      // Timeout with a partial second word pending.
      img = {8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB};
      send_image(img, 1, 1'b0);
      repeat (TO + 5) begin @(posedge clk); #1; end
      exp = {'{32'd0, 32'h04030201}};
      cmp_writes("to", exp, 1'b0);
      chk("to_err", load_err, 1);
      chk("to_busy", busy, 0);
      chk("to_done", load_done, 0);
      chk("to_corerst", core_rst_n, 0);
      chk("to_addr", mem_addr, 0);
      make_image(1, 1'b0, img);
      model(img, 0, 15, exp);
      send_image(img, 1, 1'b0);
      settle();
      cmp_writes("to2", exp, 1'b0);
      chk("to2_done", load_done, 1);
      chk("to2_err_sticky", load_err, 1);
      do_reload("to2");

      // Asynchronous reset mid-image.
      send_byte(8'h01, 1, 1'b0);
      send_byte(8'h11, 1, 1'b0);
      send_byte(8'h22, 1, 1'b0);
      rst_n = 1'b0;
      #2;
      chk("ar_we", mem_we, 0);         chk("ar_addr", mem_addr, 0);
      chk("ar_wdata", mem_wdata, 0);   chk("ar_corerst", core_rst_n, 0);
      chk("ar_busy", busy, 0);         chk("ar_done", load_done, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      img = {8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
      if (CKS_EN) img.push_back(8'h44);
      send_image(img, 0, 1'b0);
      settle();
      exp = {'{32'd0, 32'h44332211}};
      cmp_writes("ar", exp, 1'b0);
      chk("ar_done2", load_done, 1);

      // Bytes in DONE are ignored; reload beats a same-cycle byte.
      send_byte(8'h05, 1, 1'b0);
      send_byte(8'h06, 0, 1'b0);
      send_byte(8'h07, 1, 1'b0);
      settle();
      exp = {};
      cmp_writes("dn", exp, 1'b0);
      chk("dn_done", load_done, 1);
      reload = 1'b1; rx_data = 8'h02; rx_valid = 1'b1;
      @(posedge clk); #1;
      reload = 1'b0; rx_valid = 1'b0;
      chk("dn_rl_done", load_done, 0);
      chk("dn_rl_corerst", core_rst_n, 0);
      img = {8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      if (CKS_EN) img.push_back(xor_payload(img));
      send_image(img, 1, 1'b0);
      settle();
      exp = {'{32'd0, 32'hEFBEADDE}};
      cmp_writes("dn2", exp, 1'b0);
      chk("dn2_done", load_done, 1);
      chk("dn2_corerst", core_rst_n, 1);

      // Address wrap on the narrow-address instance.
      make_image(2, 1'b0, img);
      model(img, 3, 2, exp);
      send_image(img, 2, 1'b1);
      settle();
      cmp_writes("wrap", exp, 1'b1);
      chk("wrap_err", w_load_err, 0);
      chk("wrap_done", w_load_done, 1);
      chk("wrap_corerst", w_core_rst_n, 1);
      chk("wrap_busy", w_busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
